reg_word_serializer: RTL
========================

# reg_word_serializer

Transmit end for 32-bit register words: accepts a parallel word through a valid/ready handshake, captures it, and shifts it out on a single serial line as a framed bit stream. The frame is start bit, data LSB-first, optional even parity, and stop bit. It sits after the 32-bit register stage and drives an off-block serial link whose receiver rebuilds the word into a register.

## Interface
Parameters:
- WIDTH, 32: data word width, ≥1
- DIV, 4: clock cycles per serial bit, ≥1
- PARITY_EN, 1: 1 = append even-parity bit, 0 = no parity bit

Ports:
- CK  in  1  clock, all logic on rising edge
- RD  in  1  reset; synchronous, active-high
- D  in  WIDTH  word to send, sampled only on accept
- LOAD_V  in  1  D is valid
- LOAD_R  out  1  block can accept a word (high only in IDLE and not in reset)
- TXD  out  1  serial output, idle high, registered
- BUSY  out  1  frame in progress (any state other than IDLE)
- DONE  out  1  one-cycle pulse when a frame completes

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: TXD=1. Accept occurs when LOAD_V && LOAD_R. On accept:
  - D is copied into the shift register.
  - Parity is computed from the captured word: XOR of all bits, so that data ones plus the parity bit is even.
  - The bit index is cleared and the FSM moves to START.
- START: TXD=0 for DIV cycles, then DATA.
- DATA: TXD = shift_reg[0] for DIV cycles per bit.
  - The shift register shifts right after each bit.
  - After WIDTH bits, go to PARITY if PARITY_EN, else to STOP.
- PARITY: TXD = parity bit for DIV cycles, then STOP.
- STOP: TXD=1 for DIV cycles, then IDLE with DONE=1 in that first IDLE cycle.
- Counters:
  - The divide counter runs 0..DIV-1 and wraps.
  - The bit index is a $clog2(WIDTH+1)-bit counter, 0..WIDTH-1.
  - Neither counter may overflow for WIDTH=32 or DIV=1.
- LOAD_V while BUSY is ignored. D changes after accept have no effect.
- DONE is high in exactly one cycle per completed frame. That cycle is IDLE, so LOAD_R=1 and an accept in it is legal (back-to-back).

## Timing
- Reset values, applied at the next edge after RD=1 is sampled: state IDLE, TXD=1, BUSY=0, DONE=0, counters 0, shift register 0. LOAD_R=0 while RD=1 and LOAD_R=1 in the first cycle after RD deasserts.
- Accept at edge n: TXD=0 and BUSY=1 from cycle n+1.
- Frame length: F = (2 + WIDTH + PARITY_EN) × DIV cycles. With defaults, F = 140.
- DONE is high in cycle n+1+F. BUSY is low in that same cycle.
- Back-to-back: if an accept happens in the DONE cycle, the next START follows immediately. The line then shows exactly one idle-high cycle between the stop bit and the next start.
- Reset mid-frame:
  - The frame is aborted and TXD=1 on the next edge.
  - No DONE pulse is produced.
  - Captured data is discarded.
- RD=1 together with LOAD_V=1: reset wins and no accept occurs.

## Structure
- Shared package: the tx_state_t enum (IDLE, START, DATA, PARITY, STOP) and the localparam TX_IDLE_LEVEL = 1'b1. The receive end imports the same definitions.
- One sub-module: ser_tick_gen (parameter DIV). It takes CK, RD and a clear input, and outputs a one-cycle bit_end pulse when the divide counter reaches DIV-1.
- The FSM, shift register and parity logic live in the top module.

## Test plan
Defaults are WIDTH=32, DIV=4, PARITY_EN=1 unless stated.
- Reset: hold RD=1 for 2 cycles with LOAD_V=1 → TXD=1, BUSY=0, DONE=0, LOAD_R=0; after release LOAD_R=1 and no frame starts until LOAD_V.
- Load 0xA5A5A5A5 → TXD=0 for 4 cycles, then data bits 1,0,1,0,0,1,0,1 repeated ×4 (4 cycles each), then parity 0, then stop 1; DONE pulses 141 cycles after accept.
- Load 0x00000001 → first data bit 1, remaining 31 data bits 0, parity bit 1. Repeat with PARITY_EN=0 → no parity slot, DONE at accept+137.
- Back-to-back: LOAD_V held high with words 0x12345678 then 0x87654321 → second accept happens in the DONE cycle, exactly one TXD=1 idle cycle between frames, and both words are serialized intact.
- Mid-frame disturbance:
  - Drive LOAD_V=1 with D=0xFFFFFFFF at data bit 5 → the word is ignored and the current frame is unchanged.
  - Assert RD at data bit 10 → TXD=1, BUSY=0 next cycle, and no DONE pulse.
- DIV=1: load 0x80000000 → frame is 35 cycles, the last data bit is 1, parity is 1, and DONE is at accept+36.

Source files
------------

// File: rtl/reg_word_serializer_pkg.sv
// ---------------------------------------------------------------------------
// reg_word_serializer_pkg
// Definitions shared by both ends of the register-word serial link.
// The receive end imports the same state encoding and line idle level, so
// both sides agree on what the line looks like between frames.
//   tx_state_t     : frame sequencer states (IDLE, START, DATA, PARITY, STOP)
//   TX_IDLE_LEVEL  : level of the serial line when no frame is in flight
// ---------------------------------------------------------------------------
package reg_word_serializer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic TX_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/reg_word_serializer_ser_tick_gen.sv
// ---------------------------------------------------------------------------
// ser_tick_gen
// Bit-period divider for the serializer. It counts 0..DIV-1 and wraps. It
// flags the last clock cycle of every serial bit so the sequencer knows when
// to move on to the next bit.
// Ports:
//   CK      : clock, rising edge
//   RD      : synchronous active-high reset
//   clear   : holds the counter at 0, so a new frame starts on a bit boundary
//   bit_end : high in the last cycle of the current bit period
// ---------------------------------------------------------------------------
module ser_tick_gen #(
  parameter int DIV = 4
) (
  input  logic CK,
  input  logic RD,
  input  logic clear,
  output logic bit_end
);

  // Use at least one bit, so that DIV=1 still gives a legal (constant-zero)
  // counter.
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;

  always_ff @(posedge CK) begin
    if (RD || clear) begin
      div_cnt <= '0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign bit_end = (div_cnt == LAST);

endmodule

// File: rtl/reg_word_serializer.sv
// ---------------------------------------------------------------------------
// reg_word_serializer
// Takes a register word through a valid/ready handshake and sends it on one
// serial line. The frame is a start bit, WIDTH data bits LSB-first, an
// optional even-parity bit, and a stop bit. Each bit lasts DIV clock cycles.
// Ports:
//   CK     : clock, rising edge
//   RD     : synchronous active-high reset
//   D      : word to send, sampled only on accept
//   LOAD_V : D is valid
//   LOAD_R : ready to accept a word (IDLE and not in reset)
//   TXD    : registered serial output, idle high
//   BUSY   : a frame is in progress
//   DONE   : one-cycle pulse in the first IDLE cycle after a frame
// ---------------------------------------------------------------------------
module reg_word_serializer
  import reg_word_serializer_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DIV       = 4,
  parameter int PARITY_EN = 1
) (
  input  logic             CK,
  input  logic             RD,
  input  logic [WIDTH-1:0] D,
  input  logic             LOAD_V,
  output logic             LOAD_R,
  output logic             TXD,
  output logic             BUSY,
  output logic             DONE
);

  // One extra index bit, so the counter range 0..WIDTH-1 never wraps early.
  localparam int IW = $clog2(WIDTH + 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);

  tx_state_t        state, state_n;
  logic [WIDTH-1:0] shift_reg, shift_n;
  logic [IW-1:0]    bit_idx, bit_idx_n;
  logic             parity, parity_n;
  logic             txd_r, txd_n;
  logic             done_r, done_n;
  logic             accept;
  logic             bit_end;
  logic             tick_clear;

  assign LOAD_R     = (state == IDLE) && !RD;
  assign accept     = LOAD_V && LOAD_R;
  assign tick_clear = (state == IDLE);
  assign BUSY       = (state != IDLE);
  assign TXD        = txd_r;
  assign DONE       = done_r;

  ser_tick_gen #(.DIV(DIV)) u_tick (
    .CK      (CK),
    .RD      (RD),
    .clear   (tick_clear),
    .bit_end (bit_end)
  );

  // TXD is a register. So each transition loads the line level that belongs
  // to the state being entered, not the level of the state being left.
  always_comb begin
    state_n   = state;
    shift_n   = shift_reg;
    bit_idx_n = bit_idx;
    parity_n  = parity;
    txd_n     = txd_r;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        txd_n = TX_IDLE_LEVEL;
        if (accept) begin
          shift_n   = D;
          parity_n  = ^D;
          bit_idx_n = '0;
          state_n   = START;
          txd_n     = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          txd_n   = shift_reg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_n = shift_reg >> 1;
          if (bit_idx == LAST_BIT) begin
            bit_idx_n = '0;
            if (PARITY_EN != 0) begin
              state_n = PARITY;
              txd_n   = parity;
            end else begin
              state_n = STOP;
              txd_n   = TX_IDLE_LEVEL;
            end
          end else begin
            bit_idx_n = bit_idx + 1'b1;
            txd_n     = shift_n[0];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          txd_n   = TX_IDLE_LEVEL;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_n = IDLE;
          txd_n   = TX_IDLE_LEVEL;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        txd_n   = TX_IDLE_LEVEL;
      end
    endcase
  end

  always_ff @(posedge CK) begin
    if (RD) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // A reset aborts any frame in flight and discards the captured word.
  always_ff @(posedge CK) begin
    if (RD) begin
      shift_reg <= '0;
      bit_idx   <= '0;
      parity    <= 1'b0;
      txd_r     <= TX_IDLE_LEVEL;
      done_r    <= 1'b0;
    end else begin
      shift_reg <= shift_n;
      bit_idx   <= bit_idx_n;
      parity    <= parity_n;
      txd_r     <= txd_n;
      done_r    <= done_n;
    end
  end

endmodule
